// File: rtl/bch31_chien_ctrl.sv
// Chien-search sequencer for BCH(31,k) over GF(2^5), x^5+x^2+1.
// Ports: clk, rst (async low), start, sigma[5*(T+1)] in; busy,
// loc_valid/loc_ready/loc_pos stream, done, num_err, fail out.
// Optional macro BCH31_DEGCHECK_EN: flags fail when roots != degree.
module bch31_chien_ctrl #(
    parameter int T = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5*(T+1)-1:0] sigma,
    output logic               busy,
    output logic               loc_valid,
    input  logic               loc_ready,
    output logic [4:0]         loc_pos,
    output logic               done,
    output logic [4:0]         num_err,
    output logic               fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [T:0][4:0]  r_q, r_d, r_adv;
    logic [4:0]       n_q, n_d;
    logic [4:0]       num_err_q, num_err_d, num_err_inc;
    logic [4:0]       loc_pos_q, loc_pos_d;
    logic             loc_valid_q, loc_valid_d;
    logic             done_q, done_d;
    logic             skip_q, skip_d;
    logic [4:0]       sum;

    // x * alpha^-1, using alpha^-1 = alpha^4 + alpha
    function automatic logic [4:0] mul_ainv(input logic [4:0] x);
        return {1'b0, x[4:1]} ^ (x[0] ? 5'b10010 : 5'b00000);
    endfunction

    // r_k advances by alpha^-k each scanned position
    always_comb begin
        sum = '0;
        r_adv = r_q;
        for (int k = 0; k <= T; k++) begin
            sum = sum ^ r_q[k];
            for (int j = 0; j < T; j++) begin
                if (j < k) r_adv[k] = mul_ainv(r_adv[k]);
            end
        end
    end

    assign num_err_inc = (num_err_q == 5'd31) ? num_err_q
                                              : num_err_q + 5'd1;

`ifdef BCH31_DEGCHECK_EN
    localparam int DW = (T > 1) ? $clog2(T + 1) : 1;
    logic [DW-1:0] deg_q, deg_d, deg_in;
    logic          fail_q, fail_d;

    always_comb begin
        deg_in = '0;
        for (int k = 0; k <= T; k++) begin
            if (sigma[5*k +: 5] != 5'd0) deg_in = DW'(k);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        n_d         = n_q;
        num_err_d   = num_err_q;
        loc_pos_d   = loc_pos_q;
        loc_valid_d = loc_valid_q;
        skip_d      = skip_q;
        done_d      = 1'b0;
`ifdef BCH31_DEGCHECK_EN
        deg_d       = deg_q;
        fail_d      = fail_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k <= T; k++) r_d[k] = sigma[5*k +: 5];
                    n_d       = '0;
                    num_err_d = '0;
                    // all-zero locator passes through one idle SCAN cycle
                    skip_d    = (sigma == '0);
                    state_d   = S_SCAN;
`ifdef BCH31_DEGCHECK_EN
                    deg_d     = deg_in;
                    fail_d    = 1'b0;
`endif
                end
            end
            S_SCAN: begin
                if (skip_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    r_d = r_adv;
                    n_d = n_q + 5'd1;
                    if (sum == 5'd0) begin
                        loc_valid_d = 1'b1;
                        loc_pos_d   = n_q;
                        num_err_d   = num_err_inc;
                        state_d     = S_HOLD;
                    end else if (n_q == 5'd30) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (loc_ready) begin
                    loc_valid_d = 1'b0;
                    if (loc_pos_q == 5'd30) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef BCH31_DEGCHECK_EN
        if (done_d) begin
            fail_d = skip_q |
                     (num_err_d != {{(5-DW){1'b0}}, deg_q});
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            n_q         <= '0;
            num_err_q   <= '0;
            loc_pos_q   <= '0;
            loc_valid_q <= 1'b0;
            done_q      <= 1'b0;
            skip_q      <= 1'b0;
`ifdef BCH31_DEGCHECK_EN
            deg_q       <= '0;
            fail_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            n_q         <= n_d;
            num_err_q   <= num_err_d;
            loc_pos_q   <= loc_pos_d;
            loc_valid_q <= loc_valid_d;
            done_q      <= done_d;
            skip_q      <= skip_d;
`ifdef BCH31_DEGCHECK_EN
            deg_q       <= deg_d;
            fail_q      <= fail_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign loc_valid = loc_valid_q;
    assign loc_pos   = loc_pos_q;
    assign done      = done_q;
    assign num_err   = num_err_q;
`ifdef BCH31_DEGCHECK_EN
    assign fail      = fail_q;
`else
    assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_bch31_chien_ctrl.sv
// Directed bench for bch31_chien_ctrl.
// Hand-derived locators, positions and done-cycle numbers.
module tb_bch31_chien_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] sigma = '0;
    logic        busy;
    logic        loc_valid;
    logic        loc_ready = 1'b1;
    logic [4:0]  loc_pos;
    logic        done;
    logic [4:0]  num_err;
    logic        fail;

    int checks = 0;
    int failures = 0;

    int got[$];
    int done_cyc;
    int cap_num;
    int cap_fail;
    int stall_bad;
    int busy1;
    int exp_fail_deg;

    always #5 clk = ~clk;

    bch31_chien_ctrl #(.T(3)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .sigma     (sigma),
        .busy      (busy),
        .loc_valid (loc_valid),
        .loc_ready (loc_ready),
        .loc_pos   (loc_pos),
        .done      (done),
        .num_err   (num_err),
        .fail      (fail)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int s3, input int s2,
                                       input int s1, input int s0);
        return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    endfunction

    // Cycle c is the period after start edge c-1; done_cyc uses that count.
    task automatic run(input logic [19:0] s, input int stall);
        int left;
        int first;
        int held;
        got.delete();
        done_cyc  = -1;
        cap_num   = -1;
        cap_fail  = -1;
        stall_bad = 0;
        busy1     = -1;
        left      = stall;
        first     = 1;
        held      = -1;
        @(negedge clk);
        sigma     = s;
        start     = 1'b1;
        loc_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sigma = '0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) busy1 = int'(busy);
            if (done) begin
                done_cyc = cyc;
                cap_num  = int'(num_err);
                cap_fail = int'(fail);
                break;
            end
            if (loc_valid) begin
                if (held < 0) held = int'(loc_pos);
                if (first != 0 && left > 0) begin
                    if (int'(loc_pos) != held) stall_bad++;
                    loc_ready = 1'b0;
                    left--;
                end else begin
                    if (first != 0 && int'(loc_pos) != held) stall_bad++;
                    loc_ready = 1'b1;
                    got.push_back(int'(loc_pos));
                    first = 0;
                end
            end else begin
                loc_ready = 1'b1;
            end
        end
        chk("done_seen", int'(done_cyc > 0), 1);
    endtask

    task automatic after_done(input string tag, input int exp_num);
        @(negedge clk);
        chk({tag, "_done_drop"}, int'(done), 0);
        chk({tag, "_busy_drop"}, int'(busy), 0);
        chk({tag, "_num_held"}, int'(num_err), exp_num);
    endtask

    function automatic int pos_at(input int i);
        return (i < got.size()) ? got[i] : 99;
    endfunction

    initial begin
`ifdef BCH31_DEGCHECK_EN
        exp_fail_deg = 1;
`else
        exp_fail_deg = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(loc_valid), 0);
        chk("rst_pos", int'(loc_pos), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_num", int'(num_err), 0);
        chk("rst_fail", int'(fail), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // sigma0 only: no roots
        run(mk(0, 0, 0, 1), 0);
        chk("noroot_busy1", busy1, 1);
        chk("noroot_n", got.size(), 0);
        chk("noroot_cyc", done_cyc, 32);
        chk("noroot_num", cap_num, 0);
        chk("noroot_fail", cap_fail, 0);
        after_done("noroot", 0);

        // 1 + a^5 x: error at 5
        run(mk(0, 0, 5, 1), 0);
        chk("one_n", got.size(), 1);
        chk("one_p0", pos_at(0), 5);
        chk("one_cyc", done_cyc, 33);
        chk("one_num", cap_num, 1);
        chk("one_fail", cap_fail, 0);

        // errors at 3 and 10
        run(mk(0, 28, 25, 1), 0);
        chk("two_n", got.size(), 2);
        chk("two_p0", pos_at(0), 3);
        chk("two_p1", pos_at(1), 10);
        chk("two_cyc", done_cyc, 34);
        chk("two_num", cap_num, 2);
        chk("two_fail", cap_fail, 0);
        after_done("two", 2);

        // same with a 5-cycle stall on the first location
        run(mk(0, 28, 25, 1), 5);
        chk("stall_n", got.size(), 2);
        chk("stall_p0", pos_at(0), 3);
        chk("stall_p1", pos_at(1), 10);
        chk("stall_stable", stall_bad, 0);
        chk("stall_cyc", done_cyc, 39);
        chk("stall_num", cap_num, 2);

        // boundary positions 0 and 30
        run(mk(0, 0, 1, 1), 0);
        chk("p0_p0", pos_at(0), 0);
        chk("p0_n", got.size(), 1);
        chk("p0_cyc", done_cyc, 33);
        run(mk(0, 0, 18, 1), 0);
        chk("p30_p0", pos_at(0), 30);
        chk("p30_n", got.size(), 1);
        chk("p30_cyc", done_cyc, 33);
        chk("p30_fail", cap_fail, 0);

        // 1 + x + x^2 has no roots in GF(32)
        run(mk(0, 1, 1, 1), 0);
        chk("nor_n", got.size(), 0);
        chk("nor_num", cap_num, 0);
        chk("nor_fail", cap_fail, exp_fail_deg);
        chk("nor_cyc", done_cyc, 32);
        after_done("nor", 0);

        // all-zero locator skips the scan
        run(mk(0, 0, 0, 0), 0);
        chk("zero_cyc", done_cyc, 2);
        chk("zero_num", cap_num, 0);
        chk("zero_fail", cap_fail, exp_fail_deg);
        chk("zero_n", got.size(), 0);

        // reset while holding a location
        @(negedge clk);
        sigma     = mk(0, 0, 5, 1);
        start     = 1'b1;
        loc_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (loc_valid) begin
                    seen = 1;
                    break;
                end
            end
            chk("hold_reached", seen, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("hrst_busy", int'(busy), 0);
        chk("hrst_valid", int'(loc_valid), 0);
        chk("hrst_pos", int'(loc_pos), 0);
        chk("hrst_num", int'(num_err), 0);
        repeat (2) @(negedge clk);
        chk("hrst_done", int'(done), 0);
        chk("hrst_fail", int'(fail), 0);
        rst_n     = 1'b1;
        loc_ready = 1'b1;
        @(negedge clk);
        run(mk(0, 0, 5, 1), 0);
        chk("rescan_n", got.size(), 1);
        chk("rescan_p0", pos_at(0), 5);
        chk("rescan_num", cap_num, 1);
        chk("rescan_cyc", done_cyc, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
